// File: rtl/button_cond_pkg.sv
// Shared types and defaults for the button conditioner: per-channel debounce
// state encoding, default timing parameters and a state-to-level helper.
package button_cond_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_CONF_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_CONF_LOW  = 2'd3
  } btn_state_e;

  localparam int SAMPLE_CNT_MAX_DEF = 25000;
  localparam int PULSE_CNT_MAX_DEF  = 150;

  // A channel keeps reporting its old level until confirmation completes.
  function automatic logic state_level(input btn_state_e s);
    return (s == ST_HIGH) || (s == ST_CONF_LOW);
  endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for asynchronous inputs, WIDTH bits wide.
// Latency 2 clk; flops carry no reset.
module synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    meta_q <= async_in;
    sync_q <= meta_q;
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces WIDTH button lines: sampled on a shared tick, level changes after
// PULSE_CNT_MAX agreeing samples; level and edge pulses are registered.
module button_conditioner
  import button_cond_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = SAMPLE_CNT_MAX_DEF,
  parameter int PULSE_CNT_MAX  = PULSE_CNT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int CW = $clog2(SAMPLE_CNT_MAX);
  localparam int AW = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SAMPLE_CNT_MAX - 1);
  localparam logic [AW-1:0] AGREE_ONE  = AW'(1);
  localparam logic [AW-1:0] AGREE_DONE = AW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0] sync_w;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick;

  synchronizer #(.WIDTH(WIDTH)) u_sync (
    .clk      (clk),
    .async_in (async_in),
    .sync_out (sync_w)
  );

  // Counter starts at 0 on release, so the first tick lands on edge SAMPLE_CNT_MAX.
  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    btn_state_e    state_q, state_d;
    logic [AW-1:0] agree_q, agree_d;
    logic [AW-1:0] agree_inc;
    logic          level_q, level_d;
    logic          rise_q, fall_q;
    logic          s;

    assign s         = sync_w[g];
    assign agree_inc = agree_q + AW'(1);

    always_comb begin
      state_d = state_q;
      agree_d = agree_q;
      if (tick) begin
        unique case (state_q)
          ST_LOW: begin
            if (s) begin
              if (AGREE_DONE == AGREE_ONE) begin
                state_d = ST_HIGH;
                agree_d = '0;
              end else begin
                state_d = ST_CONF_HIGH;
                agree_d = AGREE_ONE;
              end
            end
          end
          ST_CONF_HIGH: begin
            if (!s) begin
              state_d = ST_LOW;
              agree_d = '0;
            end else if (agree_inc == AGREE_DONE) begin
              state_d = ST_HIGH;
              agree_d = '0;
            end else begin
              agree_d = agree_inc;
            end
          end
          ST_HIGH: begin
            if (!s) begin
              if (AGREE_DONE == AGREE_ONE) begin
                state_d = ST_LOW;
                agree_d = '0;
              end else begin
                state_d = ST_CONF_LOW;
                agree_d = AGREE_ONE;
              end
            end
          end
          ST_CONF_LOW: begin
            if (s) begin
              state_d = ST_HIGH;
              agree_d = '0;
            end else if (agree_inc == AGREE_DONE) begin
              state_d = ST_LOW;
              agree_d = '0;
            end else begin
              agree_d = agree_inc;
            end
          end
          default: begin
            state_d = ST_LOW;
            agree_d = '0;
          end
        endcase
      end
    end

    assign level_d = state_level(state_d);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_LOW;
        agree_q <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        agree_q <= agree_d;
        level_q <= level_d;
        rise_q  <= level_d & ~level_q;
        fall_q  <= ~level_d & level_q;
      end
    end

    assign level_out[g]  = level_q;
    assign rise_pulse[g] = rise_q;
    assign fall_pulse[g] = fall_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner (WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3):
// directed stimulus pushes expected output events; a monitor pops and compares.
module tb_button_conditioner;

  localparam int W = 2;
  localparam int S = 4;
  localparam int P = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] async_in;
  logic [W-1:0] level_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;

  button_conditioner #(
    .WIDTH          (W),
    .SAMPLE_CNT_MAX (S),
    .PULSE_CNT_MAX  (P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .async_in   (async_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges since reset release.
  int cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] prev_lvl = 2'b00;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_ev(input int c, input logic [1:0] lvl,
                           input logic [1:0] rise, input logic [1:0] fall);
    exp_t e;
    e.cyc = c; e.lvl = lvl; e.rise = rise; e.fall = fall;
    exp_q.push_back(e);
  endtask

  // Any pulse or level change is an output event and must match the queue head.
  always @(negedge clk) begin
    if (rst) begin
      prev_lvl = 2'b00;
    end else begin
      if (rise_pulse != 2'b00 || fall_pulse != 2'b00 || level_out != prev_lvl) begin
        if (exp_q.size() == 0) begin
          check("spurious_event_cycle", cyc, -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("event_level", int'(level_out), int'(e.lvl));
          check("event_rise",  int'(rise_pulse), int'(e.rise));
          check("event_fall",  int'(fall_pulse), int'(e.fall));
        end
      end
      prev_lvl = level_out;
    end
  end

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int c, input logic [1:0] v);
    go_to(c);
    async_in = v;
  endtask

  initial begin
    rst      = 1'b1;
    async_in = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_level", int'(level_out), 0);
    check("reset_rise",  int'(rise_pulse), 0);
    check("reset_fall",  int'(fall_pulse), 0);
    rst = 1'b0;

    // Idle low: nothing may happen.
    go_to(40);
    check("idle_level", int'(level_out), 0);

    // Short glitch on ch0 placed so no tick samples it.
    drive(42, 2'b01);
    drive(44, 2'b00);
    go_to(58);
    check("glitch_level", int'(level_out), 0);

    // Clean rise on ch0: ticks at 64, 68, 72.
    expect_ev(72, 2'b01, 2'b01, 2'b00);
    drive(60, 2'b01);

    // ch1 high for ticks 84, 88 only, then a clean high needing 104, 108, 112.
    drive(80, 2'b11);
    drive(88, 2'b01);
    go_to(96);
    check("abandoned_conf_level", int'(level_out), 1);
    expect_ev(112, 2'b11, 2'b10, 2'b00);
    drive(100, 2'b11);

    // Both channels fall together.
    expect_ev(132, 2'b00, 2'b00, 2'b11);
    drive(120, 2'b00);

    // ch1 high, then ch0 into CONF_HIGH with agree=2 before reset hits.
    expect_ev(152, 2'b10, 2'b10, 2'b00);
    drive(140, 2'b10);
    drive(160, 2'b11);
    go_to(170);
    check("events_before_reset", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    check("midrun_reset_level", int'(level_out), 0);
    check("midrun_reset_rise",  int'(rise_pulse), 0);
    check("midrun_reset_fall",  int'(fall_pulse), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Inputs still high: both rise only after fresh ticks at 4, 8, 12.
    expect_ev(12, 2'b11, 2'b11, 2'b00);
    go_to(11);
    check("post_reset_no_early_rise", int'(level_out), 0);
    go_to(20);
    check("post_reset_level", int'(level_out), 3);
    check("events_outstanding", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter WIDTH, default 1: number of independent input channels.
REQ-002 Parameter SAMPLE_CNT_MAX, default 25000: clock cycles per sample tick; legal values >= 2.
REQ-003 Parameter PULSE_CNT_MAX, default 150: consecutive agreeing sample ticks required to change level; legal values >= 1.
REQ-004 clk  input  1: system clock; all state changes on its rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-high.
REQ-006 async_in  input  WIDTH: raw asynchronous button or switch lines.
REQ-007 level_out  output  WIDTH: debounced level per channel.
REQ-008 rise_pulse  output  WIDTH: one-cycle pulse per channel on debounced 0->1.
REQ-009 fall_pulse  output  WIDTH: one-cycle pulse per channel on debounced 1->0.

Function
REQ-010 async_in SHALL pass through the team's existing two-flop synchronizer before any other use; sync = async_in delayed by 2 clk.
REQ-011 A shared sample counter SHALL count 0..SAMPLE_CNT_MAX-1 and wrap to 0.
REQ-012 tick SHALL be high for exactly one cycle, when the counter equals SAMPLE_CNT_MAX-1.
REQ-013 The first tick after reset release SHALL occur on the SAMPLE_CNT_MAX-th rising edge, so the synchronizer has flushed before the first sample.
REQ-014 Each channel SHALL have a 4-state FSM: LOW, CONF_HIGH, HIGH, CONF_LOW.
REQ-015 Each channel SHALL have an agree counter of width clog2(PULSE_CNT_MAX+1).
REQ-016 FSM state and agree counter SHALL change only on tick cycles.
REQ-017 LOW on tick: sync=1 -> CONF_HIGH with agree=1; sync=0 -> stay in LOW.
REQ-018 CONF_HIGH on tick: sync=1 -> agree+1; sync=0 -> LOW with agree=0.
REQ-019 HIGH and CONF_LOW SHALL mirror REQ-017 and REQ-018 with polarity inverted.
REQ-020 When the sample taken is the PULSE_CNT_MAX-th consecutive agreeing one, the FSM SHALL enter HIGH (from CONF_HIGH) or LOW (from CONF_LOW) and clear agree to 0.
REQ-021 With PULSE_CNT_MAX=1, the FSM SHALL go LOW->HIGH or HIGH->LOW directly on the first agreeing tick.
REQ-022 level_out SHALL be registered: 1 in HIGH and CONF_LOW, 0 in LOW and CONF_HIGH; it updates the cycle after the deciding tick.
REQ-023 rise_pulse/fall_pulse SHALL be registered, high exactly during the first cycle level_out shows the new value, never both at once.
REQ-024 Input glitches between ticks SHALL have no effect; only tick-sampled values count.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be handled per REQ-017 to REQ-023.
REQ-026 Worst-case latency from an async_in edge to a level_out change: 2 + PULSE_CNT_MAX*SAMPLE_CNT_MAX + 1 cycles.

Reset
REQ-027 rst asserted SHALL immediately clear the sample counter, all agree counters, FSMs (to LOW), level_out, rise_pulse and fall_pulse to 0.
REQ-028 Reset asserted mid-confirmation SHALL abandon that confirmation and produce no pulse.
REQ-029 Synchronizer flops SHALL remain unreset, as in the existing module.

Structure
REQ-030 FSM state encodings (2-bit) and default values of SAMPLE_CNT_MAX and PULSE_CNT_MAX SHALL live in the shared package button_cond_pkg.
REQ-031 The only sub-module SHALL be synchronizer (WIDTH-wide), instantiated unchanged; the per-channel FSM SHALL be a generate loop, not a sub-module.

Verification
All scenarios use WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.
REQ-032 Reset, then hold async_in=2'b00 for 40 cycles -> level_out=0, no pulses; ticks observed every 4th cycle, first on edge 4.
REQ-033 Drive async_in[0]=1 and hold -> level_out[0]=1 one cycle after the 3rd agreeing tick, rise_pulse[0]=1 for exactly 1 cycle, channel 1 unchanged.
REQ-034 Pulse async_in[0] high for 2 cycles between ticks -> no level change, no pulse.
REQ-035 Hold input high across 2 ticks, drop low before the 3rd -> FSM returns to LOW, level_out stays 0; a following clean high needs 3 fresh ticks.
REQ-036 From HIGH on both channels, drop both together -> fall_pulse=2'b11 in the same cycle, level_out=2'b00.
REQ-037 Assert rst while channel 0 is in CONF_HIGH with agree=2 -> all outputs 0 immediately; after release, no rise_pulse until 3 new agreeing ticks.
